// File: rtl/ula_pkg.sv
// ula_pkg: shared constants and types for the ula_seq16 slice-sequenced ALU.
//   NIB_W      : width of one ALU slice (4 bits)
//   mode_e     : op_m encoding (LOGIC / ARITH)
//   S_*        : op_s encodings for logic and arithmetic operations
//   state_e    : controller FSM states (IDLE / RUN / DONE)
package ula_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic {
    LOGIC = 1'b0,
    ARITH = 1'b1
  } mode_e;

  // Logic operations (op_m = LOGIC)
  localparam logic [3:0] S_AND  = 4'h0;
  localparam logic [3:0] S_OR   = 4'h1;
  localparam logic [3:0] S_XOR  = 4'h2;
  localparam logic [3:0] S_NAND = 4'h3;
  localparam logic [3:0] S_NOR  = 4'h4;
  localparam logic [3:0] S_XNOR = 4'h5;
  localparam logic [3:0] S_NOTA = 4'h6;
  localparam logic [3:0] S_NOTB = 4'h7;

  // Arithmetic operations (op_m = ARITH)
  localparam logic [3:0] S_ADD  = 4'h0;
  localparam logic [3:0] S_SUB  = 4'h1;
  localparam logic [3:0] S_RSUB = 4'h2;
  localparam logic [3:0] S_INCA = 4'h3;
  localparam logic [3:0] S_DECA = 4'h4;
  localparam logic [3:0] S_INCB = 4'h5;
  localparam logic [3:0] S_DECB = 4'h6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ula_seq16_if.sv
// ula_seq16_if: request/result bundle between a requester and ula_seq16.
//   master : drives start, op_m, op_s, op_a, op_b, cin; observes results
//   slave  : the ALU controller side
//   start/op_* /cin : operation request (sampled when the ALU is idle)
//   busy/done       : status; done is a one-cycle completion pulse
//   result/cout/equal : registered operation outputs
// Optional ULA_SEQ16_FLAGS_EN adds zero (result == 0) and neg (result MSB).
interface ula_seq16_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic         op_m;
  logic [3:0]   op_s;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         equal;
`ifdef ULA_SEQ16_FLAGS_EN
  logic         zero;
  logic         neg;
`endif

  modport master (
    output start, op_m, op_s, op_a, op_b, cin,
`ifdef ULA_SEQ16_FLAGS_EN
    input  zero, neg,
`endif
    input  busy, done, result, cout, equal
  );

  modport slave (
    input  start, op_m, op_s, op_a, op_b, cin,
`ifdef ULA_SEQ16_FLAGS_EN
    output zero, neg,
`endif
    output busy, done, result, cout, equal
  );

endinterface

// File: rtl/ula_nibble_slice.sv
// ula_nibble_slice: purely combinational 4-bit ALU slice.
//   a, b : nibble operands      m  : mode (LOGIC / ARITH)
//   s    : operation select     ci : carry-in (add) or borrow-in (sub)
//   f    : nibble result        co : carry-out or borrow-out
//   eq   : a == b
// Only logic ops and add/sub/reverse-sub are handled here; all other
// selects produce f = 0, co = 0.
module ula_nibble_slice
  import ula_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       m,
  input  logic [3:0] s,
  input  logic       ci,
  output logic [3:0] f,
  output logic       co,
  output logic       eq
);

  logic [4:0] tmp;

  always_comb begin
    f   = '0;
    co  = 1'b0;
    tmp = '0;
    if (m == ARITH) begin
      // 5-bit arithmetic: bit 4 is the carry for add and the borrow
      // (result went negative) for the subtracts.
      case (s)
        S_ADD:   tmp = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        S_SUB:   tmp = {1'b0, a} - {1'b0, b} - {4'b0, ci};
        S_RSUB:  tmp = {1'b0, b} - {1'b0, a} - {4'b0, ci};
        default: tmp = '0;
      endcase
      f  = tmp[3:0];
      co = tmp[4];
    end else begin
      case (s)
        S_AND:   f = a & b;
        S_OR:    f = a | b;
        S_XOR:   f = a ^ b;
        S_NAND:  f = ~(a & b);
        S_NOR:   f = ~(a | b);
        S_XNOR:  f = ~(a ^ b);
        S_NOTA:  f = ~a;
        S_NOTB:  f = ~b;
        default: f = '0;
      endcase
    end
  end

  assign eq = (a == b);

endmodule

// File: rtl/ula_seq16.sv
// ula_seq16: W-bit ALU (W = 4*NIBBLES) built by running one 4-bit slice
// over the operands, least-significant nibble first, one nibble per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ula_seq16_if slave port (request in, registered results out)
// Optional ULA_SEQ16_FLAGS_EN adds registered zero/neg result flags.
module ula_seq16
  import ula_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  ula_seq16_if.slave bus
);

  localparam int unsigned W  = NIB_W * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          m_q, m_d;
  logic [3:0]    s_q, s_d;
  logic          za_q, za_d, zb_q, zb_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          carry_q, carry_d;
  logic          eq_q, eq_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          equal_q, equal_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef ULA_SEQ16_FLAGS_EN
  logic          zero_q, zero_d;
  logic          neg_q, neg_d;
`endif

  logic [3:0] map_s;
  logic       map_za, map_zb, map_ci;
  logic [3:0] nib_a, nib_b, slice_f;
  logic       slice_co, slice_eq, nib_eq;

  // Inc/dec become add/sub against a masked (zero) operand with carry-in 1.
  // B+1 = 0+B+1 and B-1 = B-0-1 (reverse subtract), so B stays in the b
  // lane and only a masking flag is stored, keeping the original operands
  // intact for the equality accumulation.
  always_comb begin
    map_s  = bus.op_s;
    map_za = 1'b0;
    map_zb = 1'b0;
    map_ci = bus.cin;
    if (bus.op_m == ARITH) begin
      case (bus.op_s)
        S_INCA:  begin map_s = S_ADD;  map_zb = 1'b1; map_ci = 1'b1; end
        S_DECA:  begin map_s = S_SUB;  map_zb = 1'b1; map_ci = 1'b1; end
        S_INCB:  begin map_s = S_ADD;  map_za = 1'b1; map_ci = 1'b1; end
        S_DECB:  begin map_s = S_RSUB; map_za = 1'b1; map_ci = 1'b1; end
        default: ;
      endcase
    end else begin
      map_ci = 1'b0;
    end
  end

  assign nib_a = za_q ? '0 : a_q[NIB_W-1:0];
  assign nib_b = zb_q ? '0 : b_q[NIB_W-1:0];

  ula_nibble_slice u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .m  (m_q),
    .s  (s_q),
    .ci (carry_q),
    .f  (slice_f),
    .co (slice_co),
    .eq (slice_eq)
  );

  // With a lane masked the slice compares against zero, so equality of the
  // original operands is taken directly in that case.
  assign nib_eq = (za_q | zb_q) ? (a_q[NIB_W-1:0] == b_q[NIB_W-1:0]) : slice_eq;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    m_d      = m_q;
    s_d      = s_q;
    za_d     = za_q;
    zb_d     = zb_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    eq_d     = eq_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    equal_d  = equal_q;
`ifdef ULA_SEQ16_FLAGS_EN
    zero_d   = zero_q;
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          idx_d   = '0;
          m_d     = bus.op_m;
          s_d     = map_s;
          za_d    = map_za;
          zb_d    = map_zb;
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          carry_d = map_ci;
          eq_d    = 1'b1;
          acc_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> NIB_W;
        b_d     = b_q >> NIB_W;
        carry_d = slice_co;
        eq_d    = eq_q & nib_eq;
        acc_d   = {slice_f, acc_q[W-1:NIB_W]};
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d  = DONE;
          idx_d    = '0;
          result_d = acc_d;
          cout_d   = slice_co;
          equal_d  = eq_d;
`ifdef ULA_SEQ16_FLAGS_EN
          zero_d   = (acc_d == '0);
          neg_d    = acc_d[W-1];
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      m_q      <= 1'b0;
      s_q      <= '0;
      za_q     <= 1'b0;
      zb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      eq_q     <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      equal_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ULA_SEQ16_FLAGS_EN
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      m_q      <= m_d;
      s_q      <= s_d;
      za_q     <= za_d;
      zb_q     <= zb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      eq_q     <= eq_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      equal_q  <= equal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ULA_SEQ16_FLAGS_EN
      zero_q   <= zero_d;
      neg_q    <= neg_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.equal  = equal_q;
`ifdef ULA_SEQ16_FLAGS_EN
  assign bus.zero   = zero_q;
  assign bus.neg    = neg_q;
`endif

endmodule

// File: tb/tb_ula_seq16.sv
// tb_ula_seq16: self-checking bench for ula_seq16 (default NIBBLES = 4).
// Directed cases plus randomized operations, compared against a full-width
// arithmetic model. Flag outputs are checked when ULA_SEQ16_FLAGS_EN is set.
module tb_ula_seq16;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ula_seq16_if #(.NIBBLES(NIBBLES)) bus ();

  ula_seq16 #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [15:0] last_res = 16'h0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {equal, cout, result} computed on full-width values.
  function automatic logic [17:0] model(input logic m, input logic [3:0] s,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic cin);
    int sum;
    logic [15:0] r;
    logic co;
    r = 16'h0;
    co = 1'b0;
    sum = 0;
    if (!m) begin
      case (s)
        4'd0: r = a & b;
        4'd1: r = a | b;
        4'd2: r = a ^ b;
        4'd3: r = ~(a & b);
        4'd4: r = ~(a | b);
        4'd5: r = ~(a ^ b);
        4'd6: r = ~a;
        4'd7: r = ~b;
        default: r = 16'h0;
      endcase
    end else begin
      case (s)
        4'd0: sum = int'(a) + int'(b) + int'(cin);
        4'd1: sum = int'(a) - int'(b) - int'(cin);
        4'd2: sum = int'(b) - int'(a) - int'(cin);
        4'd3: sum = int'(a) + 1;
        4'd4: sum = int'(a) - 1;
        4'd5: sum = int'(b) + 1;
        4'd6: sum = int'(b) - 1;
        default: sum = 0;
      endcase
      r  = sum[15:0];
      co = (sum > 65535) || (sum < 0);
    end
    return {(a == b), co, r};
  endfunction

  task automatic drive_req(input logic m, input logic [3:0] s, input logic [15:0] a,
                           input logic [15:0] b, input logic cin);
    bus.start = 1'b1;
    bus.op_m  = m;
    bus.op_s  = s;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = cin;
  endtask

  task automatic scramble_inputs();
    bus.op_m = 1'($urandom);
    bus.op_s = 4'($urandom);
    bus.op_a = 16'($urandom);
    bus.op_b = 16'($urandom);
    bus.cin  = 1'($urandom);
  endtask

  // Issue one operation from IDLE (called #1 after an edge) and check it.
  task automatic run_op(input string tag, input logic m, input logic [3:0] s,
                        input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [17:0] exp;
    int lat;
    exp = model(m, s, a, b, cin);
    drive_req(m, s, a, b, cin);
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble_inputs();
    check_val({tag, ".busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) check_val({tag, ".hold"}, 32'(bus.result), 32'(last_res));
      @(posedge clk); #1;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    check_val({tag, ".latency"}, 32'(lat), 32'(NIBBLES));
    check_val({tag, ".result"}, 32'(bus.result), 32'(exp[15:0]));
    check_val({tag, ".cout"}, 32'(bus.cout), 32'(exp[16]));
    check_val({tag, ".equal"}, 32'(bus.equal), 32'(exp[17]));
`ifdef ULA_SEQ16_FLAGS_EN
    check_val({tag, ".zero"}, 32'(bus.zero), 32'(exp[15:0] == 16'h0));
    check_val({tag, ".neg"}, 32'(bus.neg), 32'(exp[15]));
`endif
    last_res = exp[15:0];
    @(posedge clk); #1;
    check_val({tag, ".done_fall"}, 32'(bus.done), 32'd0);
    check_val({tag, ".idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n_done;
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op_m = 1'b0;
    bus.op_s = 4'h0;
    bus.op_a = 16'h0;
    bus.op_b = 16'h0;
    bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.busy", 32'(bus.busy), 32'd0);
    check_val("rst.done", 32'(bus.done), 32'd0);
    check_val("rst.result", 32'(bus.result), 32'd0);
    check_val("rst.cout", 32'(bus.cout), 32'd0);
    check_val("rst.equal", 32'(bus.equal), 32'd0);
`ifdef ULA_SEQ16_FLAGS_EN
    check_val("rst.zero", 32'(bus.zero), 32'd0);
    check_val("rst.neg", 32'(bus.neg), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op("add_ripple", 1'b1, 4'h0, 16'h00FF, 16'h0F01, 1'b0);
    run_op("add_cout",   1'b1, 4'h0, 16'hFFFF, 16'h0001, 1'b0);
    run_op("sub_borrow", 1'b1, 4'h1, 16'h0000, 16'h0001, 1'b0);
    run_op("and",        1'b0, 4'h0, 16'hF0F0, 16'h3C3C, 1'b0);
    run_op("rsub_eq",    1'b1, 4'h2, 16'h1234, 16'h1234, 1'b0);
    run_op("incb",       1'b1, 4'h5, 16'h5A5A, 16'hFFFF, 1'b1);
    run_op("deca",       1'b1, 4'h4, 16'h0000, 16'h1111, 1'b1);
    run_op("decb_eq",    1'b1, 4'h6, 16'h0000, 16'h0000, 1'b0);
    run_op("arith_inv",  1'b1, 4'h9, 16'hABCD, 16'hABCD, 1'b1);
    run_op("logic_inv",  1'b0, 4'hC, 16'hFFFF, 16'h0F0F, 1'b1);
    run_op("add_cin",    1'b1, 4'h0, 16'h7FFF, 16'h0000, 1'b1);

    // Second start 2 cycles after accept must be ignored
    drive_req(1'b1, 4'h0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    drive_req(1'b0, 4'h2, 16'hFFFF, 16'h0F0F, 1'b0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        n_done++;
        check_val("hs.result", 32'(bus.result), 32'h3333);
      end
    end
    check_val("hs.ndone", 32'(n_done), 32'd1);
    check_val("hs.idle", 32'(bus.busy), 32'd0);
    last_res = 16'h3333;

    // Reset two cycles into an operation
    drive_req(1'b1, 4'h0, 16'h0101, 16'h0202, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst.busy", 32'(bus.busy), 32'd0);
    check_val("mid_rst.done", 32'(bus.done), 32'd0);
    check_val("mid_rst.result", 32'(bus.result), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    check_val("mid_rst.nodone", 32'(n_done), 32'd0);
    last_res = 16'h0;
    run_op("post_rst", 1'b1, 4'h1, 16'h8000, 16'h0001, 1'b1);

    // Randomized operations
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = 16'hFFFF;
        2: rb = 16'h0000;
        default: ;
      endcase
      run_op("rand", 1'($urandom), 4'($urandom), ra, rb, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
